// File: rtl/led_strip_pkg.sv
// Shared state encoding, default timing and the lane-select helper for the LED strip driver.
package led_strip_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4
  } state_t;

  // Default timing, in sys_clk cycles.
  localparam int T0H_DEF    = 20;
  localparam int T1H_DEF    = 40;
  localparam int TBIT_DEF   = 63;
  localparam int TLATCH_DEF = 15000;

  // Width of the bit and latch down-counters.
  localparam int CNT_W = 16;

  // One bit from each 20-bit lane field at the same bit position.
  function automatic logic [3:0] lane_bits(input logic [79:0] word, input logic [4:0] idx);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k] = word[20*k + int'(idx)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ws_bit_gen.sv
// Timed WS2812 bit waveform for four lanes in lockstep: high for T1H/T0H cycles, low for the
// rest of TBIT. A start on the done cycle chains the next bit with no gap.
module ws_bit_gen
  import led_strip_pkg::*;
#(
  parameter int T0H  = T0H_DEF,
  parameter int T1H  = T1H_DEF,
  parameter int TBIT = TBIT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [3:0] bits,
  output logic [3:0] lines,
  output logic       done
);

  localparam logic [CNT_W-1:0] TBIT_M1 = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] HI1_MIN = CNT_W'(TBIT - T1H);
  localparam logic [CNT_W-1:0] HI0_MIN = CNT_W'(TBIT - T0H);

  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [3:0]       bits_q;

  assign done = busy && (cnt == '0);

  // Bit period down-counter; reload on start, stop at terminal count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      bits_q <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= TBIT_M1;
      bits_q <= bits;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Each lane is high while the remaining count is above its low-phase length.
  always_comb begin
    lines = '0;
    for (int i = 0; i < 4; i++) begin
      lines[i] = busy && (cnt >= (bits_q[i] ? HI1_MIN : HI0_MIN));
    end
  end

endmodule

// File: rtl/led_strip_driver.sv
// Frame sequencer: on a full_ftdi rising edge, streams NUM_WORDS framebuffer words out as four
// 20-bit WS2812 lanes, prefetching each next word, then holds the lines low for the latch time.
//
//   state | meaning
//   IDLE  | lines low, waiting for a trigger (or a pending one)
//   FETCH | read strobe for the word at strip_raddr
//   LOAD  | capture read data, start bit 19
//   SEND  | shifting bits out; prefetch next word during bit 0
//   LATCH | lines low for TLATCH cycles
module led_strip_driver
  import led_strip_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int NUM_WORDS = 256,
  parameter int T0H       = T0H_DEF,
  parameter int T1H       = T1H_DEF,
  parameter int TBIT      = TBIT_DEF,
  parameter int TLATCH    = TLATCH_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        full_ftdi,
  input  logic [79:0] strip_rdata,
  output logic [7:0]  strip_raddr,
  output logic        strip_re,
  output logic        strip1,
  output logic        strip2,
  output logic        strip3,
  output logic        strip4
);

  // CLK_HZ is informational; a non-positive value has no meaning for this block.
  if (CLK_HZ <= 0) begin : g_clk_hz_unset
  end

  localparam logic [7:0]       LAST     = 8'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(TLATCH - 1);

  state_t           state, state_n;
  logic             ftdi_q, trig, pending, start_frame;
  logic [79:0]      shreg, nxt_word;
  logic [4:0]       bit_idx;
  logic             pf_re, pf_cap, pf_done;
  logic [CNT_W-1:0] lat_cnt;
  logic             gen_start, gen_done;
  logic [3:0]       gen_bits, lines;

  assign trig     = full_ftdi && !ftdi_q;
  assign strip_re = (state == FETCH) || pf_re;
  assign {strip4, strip3, strip2, strip1} = lines;

  ws_bit_gen #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_bit_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (gen_start),
    .bits    (gen_bits),
    .lines   (lines),
    .done    (gen_done)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  // Next state and bit generator control.
  always_comb begin
    state_n     = state;
    gen_start   = 1'b0;
    gen_bits    = '0;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (trig || pending) begin
          state_n     = FETCH;
          start_frame = 1'b1;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        gen_start = 1'b1;
        gen_bits  = lane_bits(strip_rdata, 5'd19);
        state_n   = SEND;
      end
      SEND: begin
        if (gen_done) begin
          if (bit_idx != 5'd0) begin
            gen_start = 1'b1;
            gen_bits  = lane_bits(shreg, bit_idx - 5'd1);
          end else if (pf_done) begin
            gen_start = 1'b1;
            gen_bits  = lane_bits(nxt_word, 5'd19);
          end else begin
            state_n = LATCH;
          end
        end
      end
      LATCH: begin
        if (lat_cnt == '0) begin
          // A trigger on the final latch cycle counts as pending and starts at once.
          if (trig || pending) begin
            state_n     = FETCH;
            start_frame = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: trigger edge, pending flag, address, word registers, prefetch and latch timer.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ftdi_q      <= 1'b0;
      pending     <= 1'b0;
      strip_raddr <= '0;
      shreg       <= '0;
      nxt_word    <= '0;
      bit_idx     <= '0;
      pf_re       <= 1'b0;
      pf_cap      <= 1'b0;
      pf_done     <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      ftdi_q <= full_ftdi;
      pf_re  <= 1'b0;
      pf_cap <= pf_re;
      if (pf_cap) nxt_word <= strip_rdata;
      if (start_frame) begin
        pending     <= 1'b0;
        strip_raddr <= '0;
      end else if (trig && (state != IDLE)) begin
        pending <= 1'b1;
      end
      case (state)
        LOAD: begin
          shreg   <= strip_rdata;
          bit_idx <= 5'd19;
          pf_done <= 1'b0;
        end
        SEND: begin
          if (gen_done) begin
            if (bit_idx != 5'd0) begin
              bit_idx <= bit_idx - 5'd1;
              // Entering bit 0: read the next word unless this is the last one.
              if ((bit_idx == 5'd1) && (strip_raddr != LAST)) begin
                strip_raddr <= strip_raddr + 8'd1;
                pf_re       <= 1'b1;
                pf_done     <= 1'b1;
              end
            end else if (pf_done) begin
              shreg   <= nxt_word;
              bit_idx <= 5'd19;
              pf_done <= 1'b0;
            end else begin
              lat_cnt <= LAT_INIT;
            end
          end
        end
        LATCH: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_strip_driver.sv
// Bench for led_strip_driver with a two-word framebuffer model and default timing.
module tb_led_strip_driver;

  localparam int NW     = 2;
  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int TBIT   = 63;
  localparam int TLATCH = 15000;
  localparam int FOLLOW = TBIT + TLATCH + 2;   // last bit start to next frame's first bit
  localparam int LIMIT  = TBIT + TLATCH + 10;  // no further rise expected within this
  localparam int FRAME_TO_LATCH_END = 2 + 40 * TBIT - TBIT + TBIT + TLATCH - 1; // fetch -> last latch cycle
  localparam int BOUND  = 20000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        full_ftdi = 1'b0;
  logic [79:0] strip_rdata = '0;
  logic [7:0]  strip_raddr;
  logic        strip_re, strip1, strip2, strip3, strip4;

  led_strip_driver #(
    .CLK_HZ(50_000_000), .NUM_WORDS(NW), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .full_ftdi(full_ftdi), .strip_rdata(strip_rdata),
    .strip_raddr(strip_raddr), .strip_re(strip_re),
    .strip1(strip1), .strip2(strip2), .strip3(strip3), .strip4(strip4)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Framebuffer: read data appears one cycle after the strobe; otherwise filler data.
  logic [79:0] mem [0:255];
  always @(posedge sys_clk) strip_rdata <= strip_re ? mem[strip_raddr] : {4{20'h5A3C9}};

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input longint act, input longint exp);
    total++;
    bad++;
    $display("FAIL %s: got=%0d want=%0d", name, act, exp);
  endtask

  typedef struct { logic [31:0] hl; int period; } bit_exp_t;
  bit_exp_t exp_bits[$];
  int       exp_addr[$];

  function automatic logic [31:0] exp_hl(input logic [79:0] w, input int idx);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = w[20*k + idx] ? 8'(T1H) : 8'(T0H);
    return r;
  endfunction

  task automatic push_frame(input logic [79:0] w0, input logic [79:0] w1, input int last_period);
    bit_exp_t e;
    logic [79:0] w;
    for (int a = 0; a < NW; a++) exp_addr.push_back(a);
    for (int wi = 0; wi < NW; wi++) begin
      w = (wi == 0) ? w0 : w1;
      for (int idx = 19; idx >= 0; idx--) begin
        e.hl     = exp_hl(w, idx);
        e.period = (wi == NW - 1 && idx == 0) ? last_period : TBIT;
        exp_bits.push_back(e);
      end
    end
  endtask

  // Output monitor: per-bit lane high times and bit periods, read addresses.
  logic [3:0] lanes, prev_lanes = '0;
  bit         in_bit = 0;
  bit         mon_en = 1;
  int         p = 0;
  int         hl [4];
  int         hi_cycles = 0, re_count = 0, frame_count = 0, fetch_cyc = 0;

  task automatic close_bit(input int per);
    bit_exp_t e;
    logic [31:0] act;
    act = {8'(hl[3]), 8'(hl[2]), 8'(hl[1]), 8'(hl[0])};
    if (exp_bits.size() == 0) begin
      fail("unexpected_bit", per, 0);
    end else begin
      e = exp_bits.pop_front();
      check("bit_high_times", act, e.hl);
      check("bit_period", per, e.period);
    end
  endtask

  always @(negedge sys_clk) begin
    lanes = {strip4, strip3, strip2, strip1};
    if (lanes != 0) hi_cycles++;
    if (mon_en) begin
      if (lanes != 0 && prev_lanes == 0) begin
        if (in_bit) close_bit(p);
        in_bit = 1;
        p = 0;
        for (int k = 0; k < 4; k++) hl[k] = 0;
      end
      if (in_bit) begin
        for (int k = 0; k < 4; k++) if (lanes[k]) hl[k]++;
        p++;
        if (p == LIMIT) begin
          close_bit(p);
          in_bit = 0;
        end
      end
    end else begin
      in_bit = 0;
    end
    prev_lanes = lanes;
    if (strip_re) begin
      re_count++;
      if (strip_raddr == 8'd0) begin
        frame_count++;
        fetch_cyc = cyc;
      end
      if (exp_addr.size() == 0) fail("unexpected_read", strip_raddr, -1);
      else check("read_addr", strip_raddr, exp_addr.pop_front());
    end
  end

  typedef struct {
    logic [79:0] w0;
    logic [79:0] w1;
    int          pulse_len;
    int          extra_trigs;
    bit          late_trig;
    int          exp_frames;
    int          exp_reads;
  } vec_t;

  vec_t vecs [2];

  initial begin
    int n, re0, fr0, h0, f, f2;
    vecs[0].w0 = {4{20'hA5A5A}};
    vecs[0].w1 = 80'h0000F_000F0_00F00_0F000;
    vecs[0].pulse_len = 7;  vecs[0].extra_trigs = 0; vecs[0].late_trig = 0;
    vecs[0].exp_frames = 1; vecs[0].exp_reads = 2;
    vecs[1].w0 = 80'h0000F_000F0_00F00_0F000;
    vecs[1].w1 = {20'hFFFFF, 20'h00000, 20'h80001, 20'h7FFFE};
    vecs[1].pulse_len = 1;  vecs[1].extra_trigs = 3; vecs[1].late_trig = 1;
    vecs[1].exp_frames = 3; vecs[1].exp_reads = 6;

    for (int i = 0; i < 256; i++) mem[i] = {4{20'hC3C3C}};

    // Reset state.
    repeat (3) @(negedge sys_clk);
    check("rst_lanes", {strip4, strip3, strip2, strip1}, 0);
    check("rst_strip_re", strip_re, 0);
    check("rst_raddr", strip_raddr, 0);
    sys_rst = 1'b0;

    // No trigger: nothing happens.
    repeat (1000) @(negedge sys_clk);
    check("idle_high_cycles", hi_cycles, 0);
    check("idle_reads", re_count, 0);

    for (int v = 0; v < 2; v++) begin
      mem[0] = vecs[v].w0;
      mem[1] = vecs[v].w1;
      re0 = re_count;
      fr0 = frame_count;
      push_frame(vecs[v].w0, vecs[v].w1, (vecs[v].extra_trigs > 0) ? FOLLOW : LIMIT);
      full_ftdi = 1'b1;
      repeat (vecs[v].pulse_len) @(negedge sys_clk);
      full_ftdi = 1'b0;
      n = 0;
      while (frame_count < fr0 + 1 && n < BOUND) begin @(negedge sys_clk); n++; end
      if (n >= BOUND) fail("wait_frame1_start", n, BOUND);
      f = fetch_cyc;
      if (vecs[v].extra_trigs > 0) begin
        push_frame(vecs[v].w0, vecs[v].w1, vecs[v].late_trig ? FOLLOW : LIMIT);
        for (int t = 0; t < vecs[v].extra_trigs; t++) begin
          while (cyc < f + 200 + 400 * t) @(negedge sys_clk);
          full_ftdi = 1'b1;
          @(negedge sys_clk);
          full_ftdi = 1'b0;
        end
      end
      if (vecs[v].late_trig) begin
        n = 0;
        while (frame_count < fr0 + 2 && n < BOUND) begin @(negedge sys_clk); n++; end
        if (n >= BOUND) fail("wait_frame2_start", n, BOUND);
        f2 = fetch_cyc;
        check("pending_frame_start", f2, f + FRAME_TO_LATCH_END + 1);
        push_frame(vecs[v].w0, vecs[v].w1, LIMIT);
        while (cyc < f2 + FRAME_TO_LATCH_END) @(negedge sys_clk);
        full_ftdi = 1'b1;
        @(negedge sys_clk);
        full_ftdi = 1'b0;
        n = 0;
        while (frame_count < fr0 + 3 && n < BOUND) begin @(negedge sys_clk); n++; end
        if (n >= BOUND) fail("wait_frame3_start", n, BOUND);
        check("latch_end_trigger_start", fetch_cyc, f2 + FRAME_TO_LATCH_END + 1);
      end
      n = 0;
      while (exp_bits.size() != 0 && n < BOUND) begin @(negedge sys_clk); n++; end
      if (n >= BOUND) fail("wait_bits_done", exp_bits.size(), 0);
      check("frames", frame_count - fr0, vecs[v].exp_frames);
      check("reads", re_count - re0, vecs[v].exp_reads);
      check("reads_outstanding", exp_addr.size(), 0);
    end

    // Reset in the middle of a bit's high phase.
    mon_en = 0;
    mem[0] = '1;
    mem[1] = '1;
    exp_addr.push_back(0);
    fr0 = frame_count;
    full_ftdi = 1'b1;
    @(negedge sys_clk);
    full_ftdi = 1'b0;
    n = 0;
    while (frame_count < fr0 + 1 && n < BOUND) begin @(negedge sys_clk); n++; end
    if (n >= BOUND) fail("wait_abort_frame_start", n, BOUND);
    f = fetch_cyc;
    while (cyc < f + 2 + 4 * TBIT + 10) @(negedge sys_clk);
    check("pre_reset_lanes", {strip4, strip3, strip2, strip1}, 4'hF);
    #2 sys_rst = 1'b1;
    #1;
    check("reset_lanes_now", {strip4, strip3, strip2, strip1}, 0);
    check("reset_strip_re_now", strip_re, 0);
    check("reset_raddr_now", strip_raddr, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    h0 = hi_cycles;
    re0 = re_count;
    repeat (2000) @(negedge sys_clk);
    check("post_reset_high_cycles", hi_cycles - h0, 0);
    check("post_reset_reads", re_count - re0, 0);
    check("post_reset_outstanding", exp_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
